// File: rtl/data_mem_pkg.sv
// Shared constants, FSM state type and image-slicing helper for the i281
// initialised data memory.
package data_mem_pkg;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

  // Word i of the flattened assembler image; b0I sits in the low byte.
  function automatic logic [WIDTH-1:0] image_word(
    input logic [DEPTH*WIDTH-1:0] img,
    input logic [ADDR_W-1:0]      idx
  );
    return img[idx*WIDTH +: WIDTH];
  endfunction

endpackage

// File: rtl/data_mem_init_if.sv
// CPU-side port of the data memory: address/write signals from the CPU,
// registered read data and load status back to it.
interface data_mem_init_if;
  import data_mem_pkg::*;

  // Handshake: the memory accepts a CPU access on any rising edge where
  // busy is 0; while busy is 1 writes are dropped and cpu_rdata reads 0.
  // load_done is a single-cycle pulse on the first cycle busy is 0.
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [WIDTH-1:0]  cpu_wdata;
  logic [WIDTH-1:0]  cpu_rdata;
  logic              busy;
  logic              load_done;

  modport master (
    output cpu_addr, cpu_we, cpu_wdata,
    input  cpu_rdata, busy, load_done
  );

  modport slave (
    input  cpu_addr, cpu_we, cpu_wdata,
    output cpu_rdata, busy, load_done
  );

endinterface

// File: rtl/data_mem_array.sv
// DEPTH x WIDTH register array with async clear, one write port and a
// registered read-before-write read port.
module data_mem_array
  import data_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write share the edge, so a same-address read sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= re ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/data_mem_init.sv
// Data memory that copies the user-data image in after reset/reload, then
// serves the CPU. Holds the loader FSM, the copy pointer and the write mux.
module data_mem_init
  import data_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] init_data,
  input  logic                   reload,
  data_mem_init_if.slave         cpu,
  output state_t                 state_dbg
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = image_word(init_data, ptr_q);
    unique case (state_q)
      LOAD: begin
        if (reload) begin
          ptr_d = '0;
        end else begin
          mem_we = 1'b1;
          // ptr parks at the last address instead of wrapping.
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = READY;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      READY: begin
        // A reload in the same cycle as a CPU write drops the write.
        if (reload) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else begin
          mem_we    = cpu.cpu_we;
          mem_waddr = cpu.cpu_addr;
          mem_wdata = cpu.cpu_wdata;
        end
      end
      default: begin
        state_d = LOAD;
        ptr_d   = '0;
      end
    endcase
  end

  data_mem_array u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (state_q == READY),
    .raddr (cpu.cpu_addr),
    .rdata (rd_q)
  );

  // Masking from state keeps stale read data hidden on the first LOAD cycle.
  assign cpu.cpu_rdata = (state_q == READY) ? rd_q : '0;
  assign cpu.busy      = (state_q == LOAD);
  assign cpu.load_done = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_data_mem_init.sv
// Directed bench for data_mem_init: load timing, CPU access, reload and
// reset behaviour against hand-computed values.
module tb_data_mem_init;
  import data_mem_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic [DEPTH*WIDTH-1:0] init_data;
  logic                   reload;
  state_t                 state_dbg;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;
  int rdata_leak = 0;

  data_mem_init_if bus ();

  data_mem_init dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_data (init_data),
    .reload    (reload),
    .cpu       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.load_done === 1'b1) done_pulses++;
    if (bus.busy === 1'b1 && bus.cpu_rdata !== 8'h00) rdata_leak++;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.busy === 1'b1 && n < 40);
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string tag);
    bus.cpu_addr = a;
    bus.cpu_we   = 1'b0;
    tick();
    check(32'(bus.cpu_rdata), 32'(exp), tag);
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    tick();
    bus.cpu_we    = 1'b0;
  endtask

  initial begin
    int n;
    int p0;

    rst_n         = 1'b0;
    reload        = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    init_data     = '0;
    init_data[7:0]  = 8'h07;
    init_data[15:8] = 8'h03;

    // Reset state
    #12;
    check(32'(bus.busy), 32'd1, "rst_busy");
    check(32'(bus.load_done), 32'd0, "rst_load_done");
    check(32'(bus.cpu_rdata), 32'd0, "rst_rdata");
    check(32'(state_dbg), 32'(LOAD), "rst_state");

    // First load, with an ignored CPU write at load cycle 3
    tick();
    rst_n = 1'b1;
    p0 = done_pulses;
    tick();
    tick();
    bus.cpu_addr  = 4'd0;
    bus.cpu_wdata = 8'hFF;
    bus.cpu_we    = 1'b1;
    tick();
    bus.cpu_we    = 1'b0;
    wait_ready(n);
    check(32'(n + 3), 32'd16, "load1_busy_cycles");
    check(32'(bus.load_done), 32'd1, "load1_done_high");
    tick();
    check(32'(bus.load_done), 32'd0, "load1_done_drop");
    check(32'(done_pulses - p0), 32'd1, "load1_pulse_count");
    check(32'(state_dbg), 32'(READY), "load1_state");
    cpu_read(4'd0, 8'h07, "rd_addr0");
    cpu_read(4'd1, 8'h03, "rd_addr1");
    cpu_read(4'd2, 8'h00, "rd_addr2");

    // READY writes, including read-before-write on the same address
    cpu_write(4'd5, 8'hA5);
    cpu_read(4'd5, 8'hA5, "rd_addr5_a5");
    cpu_write(4'd5, 8'h3C);
    check(32'(bus.cpu_rdata), 32'hA5, "rbw_old_value");
    cpu_read(4'd5, 8'h3C, "rd_addr5_3c");

    // Reload from READY; cpu_addr stays at 5 so a stale read would leak
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check(32'(bus.busy), 32'd1, "reload_busy_now");
    wait_ready(n);
    check(32'(n), 32'd16, "reload_busy_cycles");
    cpu_read(4'd5, 8'h00, "reload_addr5");
    cpu_read(4'd0, 8'h07, "reload_addr0");

    // Reload at load cycle 8
    p0 = done_pulses;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    wait_ready(n);
    check(32'(n), 32'd16, "midload_reload_cycles");
    tick();
    check(32'(done_pulses - p0), 32'd1, "midload_pulse_count");
    cpu_read(4'd1, 8'h03, "midload_addr1");

    // Reset mid-access in READY: busy rises immediately
    cpu_read(4'd0, 8'h07, "pre_rst_addr0");
    rst_n = 1'b0;
    #1;
    check(32'(bus.busy), 32'd1, "rst_ready_busy");
    check(32'(bus.cpu_rdata), 32'd0, "rst_ready_rdata");
    check(32'(state_dbg), 32'(LOAD), "rst_ready_state");
    tick();
    rst_n = 1'b1;
    wait_ready(n);
    check(32'(n), 32'd16, "rst_ready_reload_cycles");

    // Reset at load cycle 5
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check(32'(bus.busy), 32'd1, "rst_load_busy");
    check(32'(bus.load_done), 32'd0, "rst_load_done");
    tick();
    rst_n = 1'b1;
    wait_ready(n);
    check(32'(n), 32'd16, "rst_load_cycles");
    cpu_read(4'd0, 8'h07, "rst_load_addr0");
    cpu_read(4'd1, 8'h03, "rst_load_addr1");

    // Reload and write in the same READY cycle: the write is dropped
    bus.cpu_addr  = 4'd1;
    bus.cpu_wdata = 8'h55;
    bus.cpu_we    = 1'b1;
    reload        = 1'b1;
    tick();
    bus.cpu_we    = 1'b0;
    reload        = 1'b0;
    wait_ready(n);
    check(32'(n), 32'd16, "reload_we_cycles");
    cpu_read(4'd1, 8'h03, "reload_we_addr1");

    check(32'(rdata_leak), 32'd0, "rdata_zero_in_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
